opb_register_ppc2simulink: RTL and testbench
============================================

OPB_REGISTER_PPC2SIMULINK -- requirements
Module: opb_register_ppc2simulink

Interface
REQ-001 Parameters SHALL be:
- C_BASEADDR, 32'h01002400, first byte address decoded.
- C_HIGHADDR, 32'h010024FF, last byte address decoded.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex6", target family (informational).
- C_RESET_VALUE, 32'h00000000, reset value of the data register.

REQ-002 Ports SHALL be:
- OPB_Clk, in, 1, sole clock; all state on rising edge.
- OPB_Rst, in, 1, synchronous active-low reset (0 = reset).
- OPB_ABus, in, [0:31], byte address.
- OPB_BE, in, [0:3], byte enables; BE[0] covers DBus[0:7].
- OPB_DBus, in, [0:31], write data.
- OPB_RNW, in, 1, 1 = read, 0 = write.
- OPB_select, in, 1, transfer request.
- OPB_seqAddr, in, 1, sequential hint; ignored.
- Sl_DBus, out, [0:31], read data; zero except during a read ack.
- Sl_xferAck, out, 1, one-cycle transfer acknowledge.
- Sl_errAck, out, 1, constant 0.
- Sl_retry, out, 1, constant 0.
- Sl_toutSup, out, 1, constant 0.
- user_data_out, out, [31:0], data register to fabric.
- user_update, out, 1, one-cycle pulse on data-register write.

REQ-003 Bit order SHALL be OPB_DBus[i] <-> user bit 31-i, for both write data and Sl_DBus.

Function
REQ-004 A hit SHALL be OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; the word offset is (OPB_ABus - C_BASEADDR)>>2.
REQ-005 Offset 0 SHALL be the data register (R/W); offset 1 the write counter (RO); all other offsets are reserved: reads return 0, writes are acked and discarded.
REQ-006 FSM states SHALL be IDLE, ACK and GAP.
- IDLE -> ACK on a hit.
- ACK -> GAP unconditionally.
- GAP -> IDLE unconditionally.
- Consequence: maximum throughput is one transfer per 3 cycles.
REQ-007 On the IDLE->ACK edge, the block SHALL capture the write lanes or the read data; Sl_xferAck=1 for exactly the ACK cycle, so latency is 1 cycle from hit to ack.
REQ-008 A write to offset 0 SHALL update only the byte lanes with BE=1; lanes with BE=0 keep their value.
REQ-009 user_data_out SHALL show the new value in the ACK cycle.
REQ-010 user_update SHALL be 1 in the ACK cycle of a write to offset 0 with at least one BE set; otherwise it is 0.
REQ-011 The write counter SHALL be 16 bits, increment on each user_update, and wrap from 0xFFFF to 0x0000.
REQ-012 Reads of offset 1 SHALL return {16'h0000, count}, using the count value before any same-cycle increment.
REQ-013 Reads of offset 0 SHALL return the full 32-bit register regardless of BE.
REQ-014 Sl_DBus SHALL be all-zero in every cycle except the ACK cycle of a read.
REQ-015 A hit presented in ACK or GAP SHALL be ignored; a master still asserting select in IDLE is treated as a new transfer.
REQ-016 If OPB_select deasserts during ACK, the ack and any write SHALL still complete.
REQ-017 Out-of-range addresses SHALL never be acked; all outputs stay 0 and the state stays IDLE.

Reset
REQ-018 While OPB_Rst=0 at a clock edge, the block SHALL set:
- state = IDLE
- Sl_xferAck = 0, Sl_DBus = 0, user_update = 0
- user_data_out = C_RESET_VALUE
- count = 0
REQ-019 Reset during ACK SHALL abort the ack in the following cycle; a write captured in that cycle is overwritten by the reset value.
REQ-020 With OPB_Rst=1, reset SHALL have no effect on the next cycle.

Verification
REQ-021 Full write: write 0xDEADBEEF to 0x01002400 with BE=1111 -> xferAck and user_update 1 cycle later; user_data_out = 0xDEADBEEF; count = 1.
REQ-022 Partial write: with data 0xDEADBEEF, write 0x12345678 with BE=0100 -> user_data_out = 0xDE34BEEF; read of 0x01002400 returns 0xDE34BEEF.
REQ-023 Counter wrap: 65536 writes with BE=1111, then read 0x01002404 -> returns 0x00000000; after one more write, read returns 0x00000001.
REQ-024 Address range: write to 0x01002500 -> no ack, no state change; write to 0x01002408 -> acked, data register and count unchanged, user_update = 0.
REQ-025 Held select: select held high for 6 cycles -> exactly 2 acks, at cycles 1 and 4; Sl_DBus = 0 outside ack cycles.
REQ-026 Reset in ACK: OPB_Rst=0 in the ACK cycle of a write of 0xFFFFFFFF -> next cycle user_data_out = C_RESET_VALUE, xferAck = 0, count = 0.

Source files
------------

// File: rtl/opb_register_ppc2simulink.sv
// ---------------------------------------------------------------------------
// opb_register_ppc2simulink
//
// OPB slave exposing one 32-bit read/write data register to fabric logic,
// plus a read-only 16-bit counter of data-register writes.
//
//   offset 0 : data register (R/W, byte-lane write enables)
//   offset 1 : write counter (RO, {16'h0000, count})
//   others   : reserved (reads return 0, writes acked and discarded)
//
// Ports:
//   OPB_Clk        sole clock, rising edge
//   OPB_Rst        synchronous reset, active low
//   OPB_ABus       byte address (bit 0 = MSB)
//   OPB_BE         byte enables, BE[0] covers DBus[0:7]
//   OPB_DBus       write data (DBus[i] <-> user bit 31-i)
//   OPB_RNW        1 = read, 0 = write
//   OPB_select     transfer request
//   OPB_seqAddr    sequential hint, ignored
//   Sl_DBus        read data, zero outside a read ack
//   Sl_xferAck     one-cycle transfer acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup   tied low
//   user_data_out  data register to fabric
//   user_update    one-cycle pulse when the data register is written
//
// Handshake: a transfer is requested by OPB_select with an in-range address
// while the slave is IDLE; it is acknowledged by Sl_xferAck high for exactly
// the following cycle (ACK), after which one GAP cycle follows before a new
// request is accepted. Requests seen in ACK or GAP are ignored.
// ---------------------------------------------------------------------------
module opb_register_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01002400,
    parameter logic [31:0] C_HIGHADDR    = 32'h010024FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex6",
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [31:0]                 user_data_out,
    output logic                        user_update
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state;

    logic [31:0]             data_reg;
    logic [15:0]             count;
    logic [31:0]             wr_data;
    logic [31:0]             wr_merged;
    logic [C_OPB_AWIDTH-1:0] word_off;
    logic                    hit;
    logic                    be_any;

    // Sequential hint and family name carry no function here.
    localparam unused_family = C_FAMILY;
    logic unused_seq_addr;
    assign unused_seq_addr = OPB_seqAddr;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign user_data_out = data_reg;

    // Bus index 0 is the MSB, so a plain vector copy realises DBus[i] <-> bit 31-i.
    assign wr_data = OPB_DBus;

    assign hit = OPB_select
              && (OPB_ABus >= C_BASEADDR[C_OPB_AWIDTH-1:0])
              && (OPB_ABus <= C_HIGHADDR[C_OPB_AWIDTH-1:0]);

    assign word_off = (OPB_ABus - C_BASEADDR[C_OPB_AWIDTH-1:0]) >> 2;

    assign be_any = |OPB_BE;

    // Byte-lane merge: BE[i] selects user byte (3-i), i.e. bits 31-8i downto 24-8i.
    always_comb begin
        wr_merged = data_reg;
        for (int i = 0; i < C_OPB_DWIDTH/8; i++) begin
            if (OPB_BE[i]) begin
                wr_merged[31-8*i -: 8] = wr_data[31-8*i -: 8];
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) begin
            state       <= IDLE;
            Sl_xferAck  <= 1'b0;
            Sl_DBus     <= '0;
            user_update <= 1'b0;
            data_reg    <= C_RESET_VALUE;
            count       <= 16'h0000;
        end else begin
            // Pulses and read data default low; only the IDLE->ACK edge raises them.
            Sl_xferAck  <= 1'b0;
            Sl_DBus     <= '0;
            user_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        state      <= ACK;
                        Sl_xferAck <= 1'b1;
                        if (OPB_RNW) begin
                            if (word_off == '0) begin
                                Sl_DBus <= data_reg;
                            end else if (word_off == C_OPB_AWIDTH'(1)) begin
                                Sl_DBus <= {16'h0000, count};
                            end
                        end else if (word_off == '0) begin
                            data_reg <= wr_merged;
                            if (be_any) begin
                                user_update <= 1'b1;
                                count       <= count + 16'h0001;
                            end
                        end
                    end
                end
                ACK:     state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// ---------------------------------------------------------------------------
// Bench for opb_register_ppc2simulink: directed OPB transfers, a small
// reference model of the data register and write counter, and a queue of
// expected Sl_DBus values checked at each acknowledge.
// ---------------------------------------------------------------------------
module tb_opb_register_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01002400;
    localparam logic [31:0] HIGH = 32'h010024FF;

    logic        OPB_Clk;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_out;
    logic        user_update;

    opb_register_ppc2simulink dut (
        .OPB_Clk       (OPB_Clk),
        .OPB_Rst       (OPB_Rst),
        .OPB_ABus      (OPB_ABus),
        .OPB_BE        (OPB_BE),
        .OPB_DBus      (OPB_DBus),
        .OPB_RNW       (OPB_RNW),
        .OPB_select    (OPB_select),
        .OPB_seqAddr   (OPB_seqAddr),
        .Sl_DBus       (Sl_DBus),
        .Sl_xferAck    (Sl_xferAck),
        .Sl_errAck     (Sl_errAck),
        .Sl_retry      (Sl_retry),
        .Sl_toutSup    (Sl_toutSup),
        .user_data_out (user_data_out),
        .user_update   (user_update)
    );

    // Clock
    initial OPB_Clk = 1'b0;
    always #5 OPB_Clk = ~OPB_Clk;

    // Scoreboard and model state
    logic [31:0] exp_q[$];
    logic [31:0] m_data;
    logic [15:0] m_count;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One OPB transfer, started with the slave in IDLE; returns with the slave
    // back in IDLE, just after a rising edge. Select drops during ACK.
    task automatic opb_xfer(input logic [31:0] addr, input logic rnw,
                            input logic [0:3] be, input logic [31:0] wdata);
        logic        in_range;
        logic [31:0] off;
        logic        exp_upd;
        logic [31:0] exp_rd;
        in_range = (addr >= BASE) && (addr <= HIGH);
        off      = (addr - BASE) >> 2;
        exp_upd  = 1'b0;
        exp_rd   = 32'h0;
        if (in_range) begin
            if (rnw) begin
                if (off == 0)      exp_rd = m_data;
                else if (off == 1) exp_rd = {16'h0000, m_count};
            end else if (off == 0 && be != 4'b0000) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_data[31-8*i -: 8] = wdata[31-8*i -: 8];
                m_count = m_count + 16'h1;
                exp_upd = 1'b1;
            end
            exp_q.push_back(exp_rd);
        end
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_BE     = be;
        OPB_DBus   = wdata;
        OPB_select = 1'b1;
        @(posedge OPB_Clk);
        #1;
        OPB_select = 1'b0;
        OPB_DBus   = 32'h0;
        @(negedge OPB_Clk);
        check($sformatf("xfer_ack@%h", addr), {31'h0, Sl_xferAck}, {31'h0, in_range});
        if (in_range)
            check($sformatf("sl_dbus@%h", addr), Sl_DBus, exp_q.pop_front());
        else
            check($sformatf("sl_dbus_quiet@%h", addr), Sl_DBus, 32'h0);
        check($sformatf("user_update@%h", addr), {31'h0, user_update}, {31'h0, exp_upd});
        check($sformatf("user_data_out@%h", addr), user_data_out, m_data);
        check("tied_low", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
        @(posedge OPB_Clk);
        @(posedge OPB_Clk);
        #1;
    endtask

    initial begin
        logic exp_ack;
        n_checks    = 0;
        n_pass      = 0;
        m_data      = 32'h0;
        m_count     = 16'h0;
        OPB_Rst     = 1'b0;
        OPB_ABus    = 32'h0;
        OPB_BE      = 4'b0000;
        OPB_DBus    = 32'h0;
        OPB_RNW     = 1'b0;
        OPB_select  = 1'b0;
        OPB_seqAddr = 1'b0;

        // Reset
        repeat (3) @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        check("rst_ack", {31'h0, Sl_xferAck}, 32'h0);
        check("rst_dbus", Sl_DBus, 32'h0);
        check("rst_update", {31'h0, user_update}, 32'h0);
        check("rst_data", user_data_out, 32'h00000000);
        OPB_Rst = 1'b1;
        @(posedge OPB_Clk);
        #1;

        // Full write, then counter read
        opb_xfer(BASE, 1'b0, 4'b1111, 32'hDEADBEEF);
        check("full_write_value", user_data_out, 32'hDEADBEEF);
        opb_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);

        // Partial write of lane 1 only, then read back ignoring BE
        opb_xfer(BASE, 1'b0, 4'b0100, 32'h12345678);
        check("partial_write_value", user_data_out, 32'hDE34BEEF);
        opb_xfer(BASE, 1'b1, 4'b0000, 32'h0);
        opb_xfer(BASE, 1'b0, 4'b0001, 32'hAABBCC11);
        opb_xfer(BASE, 1'b0, 4'b1000, 32'h5A000000);
        opb_xfer(BASE, 1'b1, 4'b1111, 32'h0);

        // Write with no lanes enabled: acked, no update, no count
        opb_xfer(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF);
        opb_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);

        // Address range and reserved / read-only offsets
        opb_xfer(32'h01002500, 1'b0, 4'b1111, 32'h11111111);
        opb_xfer(32'h010023FC, 1'b1, 4'b1111, 32'h0);
        opb_xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'h22222222);
        opb_xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h33333333);
        opb_xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0);
        opb_xfer(32'h010024FC, 1'b1, 4'b1111, 32'h0);
        opb_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);

        // Held select: acks only on cycles 1 and 4 of a six-cycle request
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b1;
        OPB_BE     = 4'b1111;
        OPB_select = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge OPB_Clk);
            @(negedge OPB_Clk);
            exp_ack = (c == 1) || (c == 4);
            check($sformatf("held_ack_c%0d", c), {31'h0, Sl_xferAck}, {31'h0, exp_ack});
            if (exp_ack) begin
                exp_q.push_back(m_data);
                check($sformatf("held_dbus_c%0d", c), Sl_DBus, exp_q.pop_front());
            end else begin
                check($sformatf("held_dbus_c%0d", c), Sl_DBus, 32'h0);
            end
        end
        OPB_select = 1'b0;

        // Counter wrap: preload near the top instead of issuing 65k writes
        force dut.count = 16'hFFFE;
        @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        release dut.count;
        m_count = 16'hFFFE;
        opb_xfer(BASE, 1'b0, 4'b1111, 32'h01020304);
        opb_xfer(BASE, 1'b0, 4'b1111, 32'h05060708);
        opb_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);
        check("wrap_model_zero", {16'h0, m_count}, 32'h0);
        opb_xfer(BASE, 1'b0, 4'b1111, 32'h090A0B0C);
        opb_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);

        // Reset asserted in the ACK cycle of a write
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b0;
        OPB_BE     = 4'b1111;
        OPB_DBus   = 32'hFFFFFFFF;
        OPB_select = 1'b1;
        @(posedge OPB_Clk);
        #1;
        OPB_select = 1'b0;
        OPB_Rst    = 1'b0;
        @(negedge OPB_Clk);
        check("rst_in_ack_ack", {31'h0, Sl_xferAck}, 32'h1);
        check("rst_in_ack_wr", user_data_out, 32'hFFFFFFFF);
        @(negedge OPB_Clk);
        check("rst_after_ack", {31'h0, Sl_xferAck}, 32'h0);
        check("rst_after_data", user_data_out, 32'h00000000);
        check("rst_after_update", {31'h0, user_update}, 32'h0);
        OPB_Rst = 1'b1;
        m_data  = 32'h0;
        m_count = 16'h0;
        @(posedge OPB_Clk);
        #1;
        opb_xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);
        opb_xfer(BASE, 1'b1, 4'b1111, 32'h0);

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
